spi_slave_rx: RTL

Receive-side endpoint for the team's 12-bit, LSB-first SPI write link. It oversamples `sclk`, `cs` and `mosi` in the local system clock domain and reassembles each frame into a parallel word. It then presents the word with a single-cycle `done` strobe. It sits on the peripheral side of the link, opposite the SPI master. It carries no MISO path.

---
 rtl/spi_slave_rx.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_rx.sv
// spi_slave_rx
//   Receive endpoint of the 12-bit LSB-first SPI write link. sclk, cs and
//   mosi are oversampled in the clk domain. Bits are captured on falling
//   sclk and each completed frame is presented on dout with a one-cycle
//   done strobe. There is no MISO path.
//
//   Optional feature: define SPI_SLAVE_RX_FRAME_ERR_EN to pulse err when a
//   frame is aborted after at least one bit was sampled. With the macro
//   undefined, err is tied low.
//
// Ports
//   clk   : system clock, runs at least 4x the sclk rate
//   rst_n : asynchronous active-low reset
//   sclk  : SPI serial clock (asynchronous)
//   cs    : chip select, active-low (asynchronous)
//   mosi  : serial data, changed by the master on rising sclk
//   dout  : last complete received word, bit 0 is the first bit on the wire
//   done  : one-cycle pulse when dout is updated
//   busy  : high while a frame is in progress (WAIT, SHIFT, HOLD)
//   err   : one-cycle pulse on frame abort (feature macro only)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | cs_s high, no frame in progress
// WAIT  | cs_s low, waiting for the first armed sclk rise
// SHIFT | capturing bits on falling sclk
// HOLD  | frame complete, ignoring edges until cs_s goes high
module spi_slave_rx #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              done,
    output logic              busy,
    output logic              err
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic sclk_s, cs_s, mosi_s;
    logic sclk_q, cs_q;
    logic rise, fall, armed_rise;

    logic [CW-1:0]     bitcnt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic              clr_cnt, sample, capture, done_nxt;

    // Synchronizers; cs idles high so it resets to 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_q    <= sclk_s;
            cs_q      <= cs_s;
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign rise       = sclk_s & ~sclk_q;
    assign fall       = ~sclk_s & sclk_q;
    // The rise coinciding with cs dropping is not armed
    assign armed_rise = rise & ~cs_q;

    // shreg is cleared on every frame start, so OR-ing the new bit is enough
    assign shreg_nxt = shreg | (DATA_W'(mosi_s) << bitcnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    logic err_nxt;
`endif

    always_comb begin
        state_nxt = state;
        clr_cnt   = 1'b0;
        sample    = 1'b0;
        capture   = 1'b0;
        done_nxt  = 1'b0;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        err_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!cs_s) begin
                    state_nxt = WAIT;
                    clr_cnt   = 1'b1;
                end
            end
            WAIT: begin
                if (cs_s) begin
                    state_nxt = IDLE;
                    clr_cnt   = 1'b1;
                end else if (armed_rise) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // Abort wins over a coincident final fall
                if (cs_s) begin
                    state_nxt = IDLE;
                    clr_cnt   = 1'b1;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
                    err_nxt   = (bitcnt != '0);
`endif
                end else if (fall) begin
                    sample = 1'b1;
                    if (bitcnt == LAST_BIT) begin
                        capture   = 1'b1;
                        done_nxt  = 1'b1;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (cs_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt <= '0;
            shreg  <= '0;
            dout   <= '0;
            done   <= 1'b0;
        end else begin
            done <= done_nxt;
            if (clr_cnt) begin
                bitcnt <= '0;
                shreg  <= '0;
            end else if (sample) begin
                bitcnt <= bitcnt + CW'(1);
                shreg  <= shreg_nxt;
            end
            if (capture) begin
                dout <= shreg_nxt;
            end
        end
    end

`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= err_nxt;
        end
    end
`else
    assign err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule
